// File: rtl/bus_mem.sv
// -----------------------------------------------------------------------------
// bus_mem
//
// Unified memory and peripheral target for a single-cycle CPU core. One
// word-organised array serves both the instruction fetch port (rom) and the
// data port (ram). A 16-byte MMIO window holds a FIFO-buffered 8N1 serial
// transmitter and a free-running 64-bit cycle counter (mtime).
//
// All reads are combinational so the core can finish an instruction in one
// cycle. All state changes happen on the rising clock edge.
//
// Ports
//   i_sys_clk      in   1           clock
//   i_sys_rst_n    in   1           asynchronous active-low reset
//   i_rom_rd_en    in   1           fetch enable
//   i_rom_rd_addr  in   ADDR_WIDTH  fetch byte address
//   o_rom_rd_data  out  DATA_WIDTH  fetched word (combinational)
//   i_ram_rd_en    in   1           data read enable
//   i_ram_rd_addr  in   ADDR_WIDTH  data read byte address
//   o_ram_rd_data  out  DATA_WIDTH  read word (combinational)
//   i_ram_wr_en    in   1           data write enable
//   i_ram_wr_addr  in   ADDR_WIDTH  data write byte address
//   i_ram_wr_data  in   DATA_WIDTH  write data
//   i_ram_wr_mask  in   DATA_WIDTH/8 byte enables, bit i enables byte i
//   o_uart_tx      out  1           serial line, idle high
//   o_bus_err      out  1           sticky access-error flag
//
// MMIO map (offset from MMIO_BASE)
//   +0x0  TX data (write pushes wr_data[7:0] when mask[0]; reads 0)
//   +0x4  status  {overflow, tx_busy, fifo_empty, fifo_full}
//   +0x8  mtime low
//   +0xC  mtime high
//
// The MMIO registers are 32 bits wide; DATA_WIDTH is expected to be 32.
// -----------------------------------------------------------------------------
`default_nettype none

module bus_mem #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 4096,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = ADDR_WIDTH'(32'h8000_0000),
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = ADDR_WIDTH'(32'ha000_0000),
  parameter int                    UART_DIV   = 16,
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst_n,
  input  logic                    i_rom_rd_en,
  input  logic [ADDR_WIDTH-1:0]   i_rom_rd_addr,
  output logic [DATA_WIDTH-1:0]   o_rom_rd_data,
  input  logic                    i_ram_rd_en,
  input  logic [ADDR_WIDTH-1:0]   i_ram_rd_addr,
  output logic [DATA_WIDTH-1:0]   o_ram_rd_data,
  input  logic                    i_ram_wr_en,
  input  logic [ADDR_WIDTH-1:0]   i_ram_wr_addr,
  input  logic [DATA_WIDTH-1:0]   i_ram_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_ram_wr_mask,
  output logic                    o_uart_tx,
  output logic                    o_bus_err
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int DIV_W  = (UART_DIV > 1) ? $clog2(UART_DIV) : 1;

  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES  = ADDR_WIDTH'(MEM_DEPTH * 4);
  localparam logic [ADDR_WIDTH-1:0] MMIO_BYTES = ADDR_WIDTH'(16);

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_MTIMEL = 2'd2;
  localparam logic [1:0] REG_MTIMEH = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // Address decode helpers. Subtracting the base and comparing unsigned
  // against the window size catches addresses on both sides of the window
  // with a single comparison.
  // ---------------------------------------------------------------------------
  function automatic logic is_mem(input logic [ADDR_WIDTH-1:0] addr);
    return (addr - MEM_BASE) < MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] mem_index(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'((addr - MEM_BASE) >> 2);
  endfunction

  function automatic logic is_mmio(input logic [ADDR_WIDTH-1:0] addr);
    return (addr - MMIO_BASE) < MMIO_BYTES;
  endfunction

  function automatic logic [1:0] mmio_reg(input logic [ADDR_WIDTH-1:0] addr);
    return 2'((addr - MMIO_BASE) >> 2);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] result;
    result = old_val;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) result[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return result;
  endfunction

  logic                  rom_in_mem;
  logic                  rd_in_mem;
  logic                  rd_in_mmio;
  logic                  wr_in_mem;
  logic                  wr_in_mmio;
  logic [IDX_W-1:0]      rom_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      wr_idx;
  logic [1:0]            rd_sel;
  logic [1:0]            wr_sel;

  assign rom_in_mem = is_mem(i_rom_rd_addr);
  assign rd_in_mem  = is_mem(i_ram_rd_addr);
  assign rd_in_mmio = is_mmio(i_ram_rd_addr);
  assign wr_in_mem  = is_mem(i_ram_wr_addr);
  assign wr_in_mmio = is_mmio(i_ram_wr_addr);
  assign rom_idx    = mem_index(i_rom_rd_addr);
  assign rd_idx     = mem_index(i_ram_rd_addr);
  assign wr_idx     = mem_index(i_ram_wr_addr);
  assign rd_sel     = mmio_reg(i_ram_rd_addr);
  assign wr_sel     = mmio_reg(i_ram_wr_addr);

  logic [31:0] wr_word;
  logic [3:0]  wr_strb;

  assign wr_word = 32'(i_ram_wr_data);
  assign wr_strb = 4'(i_ram_wr_mask);

  // ---------------------------------------------------------------------------
  // Memory array. Not reset. Reads are asynchronous, so a read of the word
  // being written this cycle sees the old contents until the edge.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge i_sys_clk) begin
    if (i_ram_wr_en && wr_in_mem) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_ram_wr_mask[b]) mem[wr_idx][b*8 +: 8] <= i_ram_wr_data[b*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky bus error: any enabled access that lands outside memory and MMIO,
  // or a fetch that lands anywhere but memory.
  // ---------------------------------------------------------------------------
  logic access_err;
  logic bus_err;

  assign access_err = (i_rom_rd_en && !rom_in_mem) ||
                      (i_ram_rd_en && !rd_in_mem && !rd_in_mmio) ||
                      (i_ram_wr_en && !wr_in_mem && !wr_in_mmio);

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      bus_err <= 1'b0;
    end else if (access_err) begin
      bus_err <= 1'b1;
    end
  end

  assign o_bus_err = bus_err;

  // ---------------------------------------------------------------------------
  // mtime. A write to either half replaces the increment for that cycle, so
  // the untouched half simply holds (no carry leaks across).
  // ---------------------------------------------------------------------------
  logic [31:0] mtime_lo;
  logic [31:0] mtime_hi;
  logic        mtime_lo_wr;
  logic        mtime_hi_wr;

  assign mtime_lo_wr = i_ram_wr_en && wr_in_mmio && (wr_sel == REG_MTIMEL) && (|wr_strb);
  assign mtime_hi_wr = i_ram_wr_en && wr_in_mmio && (wr_sel == REG_MTIMEH) && (|wr_strb);

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      mtime_lo <= '0;
      mtime_hi <= '0;
    end else if (mtime_lo_wr) begin
      mtime_lo <= merge_bytes(mtime_lo, wr_word, wr_strb);
    end else if (mtime_hi_wr) begin
      mtime_hi <= merge_bytes(mtime_hi, wr_word, wr_strb);
    end else begin
      {mtime_hi, mtime_lo} <= {mtime_hi, mtime_lo} + 64'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO. A push into a full FIFO is still accepted when the transmitter
  // pops on the same edge, since that frees the slot being refilled.
  // ---------------------------------------------------------------------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic [7:0]       fifo_head;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push_req   = i_ram_wr_en && wr_in_mmio && (wr_sel == REG_TXDATA) && i_ram_wr_mask[0];
  assign push_ok    = push_req && (!fifo_full || pop);
  assign fifo_head  = fifo_mem[rd_ptr];

  always_ff @(posedge i_sys_clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= i_ram_wr_data[7:0];
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // TX state register. The serial line is registered from the next-state
  // values so it changes on the same edge as the state and never glitches.
  // ---------------------------------------------------------------------------
  tx_state_t        state;
  tx_state_t        state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_next;
  logic [7:0]       shift;
  logic [7:0]       shift_next;
  logic             tx_line;
  logic             tx_next;
  logic             div_last;

  assign div_last = (div_cnt == DIV_W'(UART_DIV - 1));

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx_line <= 1'b1;
    end else begin
      state   <= state_next;
      div_cnt <= div_next;
      bit_cnt <= bit_next;
      shift   <= shift_next;
      tx_line <= tx_next;
    end
  end

  // ---------------------------------------------------------------------------
  // TX next-state logic. Each state spends UART_DIV cycles; the end of STOP
  // goes straight to START when more data is waiting so frames are
  // back-to-back.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    bit_next   = bit_cnt;
    shift_next = shift;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        div_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_head;
          state_next = START;
        end
      end
      START: begin
        if (div_last) begin
          div_next   = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      DATA: begin
        if (div_last) begin
          div_next = '0;
          if (bit_cnt == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next   = bit_cnt + 3'd1;
            shift_next = {1'b0, shift[7:1]};
          end
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      STOP: begin
        if (div_last) begin
          div_next = '0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_head;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        div_next   = '0;
      end
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign o_uart_tx = tx_line;

  // ---------------------------------------------------------------------------
  // Read muxes. Disabled ports return zero; misses return zero as well and
  // are flagged through bus_err.
  // ---------------------------------------------------------------------------
  logic [3:0]            status;
  logic [DATA_WIDTH-1:0] mmio_rd_data;

  assign status = {overflow, (state != IDLE), fifo_empty, fifo_full};

  always_comb begin
    mmio_rd_data = '0;
    case (rd_sel)
      REG_STATUS: mmio_rd_data = DATA_WIDTH'(status);
      REG_MTIMEL: mmio_rd_data = DATA_WIDTH'(mtime_lo);
      REG_MTIMEH: mmio_rd_data = DATA_WIDTH'(mtime_hi);
      default:    mmio_rd_data = '0;
    endcase
  end

  always_comb begin
    o_ram_rd_data = '0;
    if (i_ram_rd_en) begin
      if (rd_in_mem) begin
        o_ram_rd_data = mem[rd_idx];
      end else if (rd_in_mmio) begin
        o_ram_rd_data = mmio_rd_data;
      end
    end
  end

  assign o_rom_rd_data = (i_rom_rd_en && rom_in_mem) ? mem[rom_idx] : '0;

endmodule

`default_nettype wire

// File: tb/tb_bus_mem.sv
// -----------------------------------------------------------------------------
// tb_bus_mem
//
// Self-checking bench for bus_mem. Stimulus drives one bus cycle at a time
// and pushes the expected responses into per-output queues; a monitor on the
// falling edge pops and compares whenever the DUT presents a response.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_bus_mem;

  localparam logic [31:0] TXDATA = 32'ha000_0000;
  localparam logic [31:0] STATUS = 32'ha000_0004;
  localparam logic [31:0] MTIMEL = 32'ha000_0008;
  localparam logic [31:0] MTIMEH = 32'ha000_000c;

  logic        clk;
  logic        rst_n;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        uart_tx;
  logic        bus_err;

  typedef struct {
    string       name;
    logic [31:0] value;
    bit          gated;
  } exp_t;

  exp_t rom_q[$];
  exp_t ram_q[$];
  exp_t tx_q[$];
  exp_t err_q[$];
  exp_t mon_e;

  int n_checks;
  int n_fail;

  bus_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (4096),
    .MEM_BASE   (32'h8000_0000),
    .MMIO_BASE  (32'ha000_0000),
    .UART_DIV   (4),
    .FIFO_DEPTH (8)
  ) dut (
    .i_sys_clk     (clk),
    .i_sys_rst_n   (rst_n),
    .i_rom_rd_en   (rom_en),
    .i_rom_rd_addr (rom_addr),
    .o_rom_rd_data (rom_data),
    .i_ram_rd_en   (rd_en),
    .i_ram_rd_addr (rd_addr),
    .o_ram_rd_data (rd_data),
    .i_ram_wr_en   (wr_en),
    .i_ram_wr_addr (wr_addr),
    .i_ram_wr_data (wr_data),
    .i_ram_wr_mask (wr_mask),
    .o_uart_tx     (uart_tx),
    .o_bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation and log misses.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic exp_t mkExp(input string n, input logic [31:0] v, input bit g);
    exp_t e;
    e.name  = n;
    e.value = v;
    e.gated = g;
    return e;
  endfunction

  function automatic void expRom(input string n, input logic [31:0] v);
    rom_q.push_back(mkExp(n, v, 1'b0));
  endfunction

  function automatic void expRomIdle(input string n, input logic [31:0] v);
    rom_q.push_back(mkExp(n, v, 1'b1));
  endfunction

  function automatic void expRam(input string n, input logic [31:0] v);
    ram_q.push_back(mkExp(n, v, 1'b0));
  endfunction

  function automatic void expRamIdle(input string n, input logic [31:0] v);
    ram_q.push_back(mkExp(n, v, 1'b1));
  endfunction

  function automatic void expTx(input string n, input logic v);
    tx_q.push_back(mkExp(n, {31'd0, v}, 1'b0));
  endfunction

  function automatic void expErr(input string n, input logic v);
    err_q.push_back(mkExp(n, {31'd0, v}, 1'b0));
  endfunction

  // Expected line level at cycle j of a back-to-back stream whose k-th frame
  // (k from 0) carries byte k+1: start 0, eight data bits LSB first, stop 1.
  function automatic logic txLevel(input int j);
    logic [9:0] f;
    f = {1'b1, 8'(j / 40 + 1), 1'b0};
    return f[(j % 40) / 4];
  endfunction

  // Responses are sampled mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    if (rom_q.size() > 0 && (rom_en || rom_q[0].gated)) begin
      mon_e = rom_q.pop_front();
      checkOutput(mon_e.name, rom_data, mon_e.value);
    end
    if (ram_q.size() > 0 && (rd_en || ram_q[0].gated)) begin
      mon_e = ram_q.pop_front();
      checkOutput(mon_e.name, rd_data, mon_e.value);
    end
    if (tx_q.size() > 0) begin
      mon_e = tx_q.pop_front();
      checkOutput(mon_e.name, {31'd0, uart_tx}, mon_e.value);
    end
    if (err_q.size() > 0) begin
      mon_e = err_q.pop_front();
      checkOutput(mon_e.name, {31'd0, bus_err}, mon_e.value);
    end
  end

  // Drive one bus cycle, then advance to just past the next rising edge.
  task automatic applyStimulus(input logic r_en, input logic [31:0] r_addr,
                               input logic d_en, input logic [31:0] d_addr,
                               input logic w_en, input logic [31:0] w_addr,
                               input logic [31:0] w_data, input logic [3:0] w_mask);
    rom_en   = r_en;
    rom_addr = r_addr;
    rd_en    = d_en;
    rd_addr  = d_addr;
    wr_en    = w_en;
    wr_addr  = w_addr;
    wr_data  = w_data;
    wr_mask  = w_mask;
    @(posedge clk);
    #1;
    rom_en = 1'b0;
    rd_en  = 1'b0;
    wr_en  = 1'b0;
  endtask

  task automatic busIdle();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'h0);
  endtask

  task automatic busRead(input logic [31:0] a);
    applyStimulus(1'b0, 32'd0, 1'b1, a, 1'b0, 32'd0, 32'd0, 4'h0);
  endtask

  task automatic busFetch(input logic [31:0] a);
    applyStimulus(1'b1, a, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'h0);
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, a, d, m);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] frame55;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rom_en   = 1'b0;
    rom_addr = '0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_mask  = '0;

    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset state");
    expTx("rst_tx", 1'b1);
    expErr("rst_err", 1'b0);
    expRam("rst_status", 32'h2);
    busRead(STATUS);
    rst_n = 1'b1;

    $display("[TB] mtime");
    expRam("mtime_zero", 32'd0);
    busRead(MTIMEL);
    repeat (99) busIdle();
    expRam("mtime_lo_100", 32'd100);
    busRead(MTIMEL);
    busWrite(MTIMEH, 32'h1, 4'hf);
    expRam("mtime_hi_written", 32'h1);
    busRead(MTIMEH);
    expRam("mtime_lo_held_then_counts", 32'd102);
    busRead(MTIMEL);

    $display("[TB] memory");
    busWrite(32'h8000_0010, 32'haabb_ccdd, 4'hf);
    busWrite(32'h8000_0010, 32'h1122_3344, 4'b0101);
    expRam("masked_rd", 32'haa22_cc44);
    expRom("masked_fetch", 32'haa22_cc44);
    applyStimulus(1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 1'b0, 32'd0, 32'd0, 4'h0);
    expRam("rd_during_wr_old", 32'haa22_cc44);
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 32'hffff_ffff, 4'hf);
    expRam("unaligned_rd", 32'hffff_ffff);
    busRead(32'h8000_0013);
    busWrite(32'h8000_3ffc, 32'h1234_5678, 4'hf);
    expRom("last_word_fetch", 32'h1234_5678);
    busFetch(32'h8000_3ffc);
    expRamIdle("rd_disabled", 32'd0);
    expRomIdle("fetch_disabled", 32'd0);
    expErr("err_clean", 1'b0);
    applyStimulus(1'b0, 32'h8000_0010, 1'b0, 32'h8000_0010, 1'b0, 32'd0, 32'd0, 4'h0);
    expRam("txdata_reads_zero", 32'd0);
    busRead(TXDATA);

    $display("[TB] address error");
    expRam("bad_rd_zero", 32'd0);
    expErr("err_not_yet", 1'b0);
    busRead(32'h7fff_fffc);
    expErr("err_set", 1'b1);
    expRam("valid_after_err", 32'hffff_ffff);
    busRead(32'h8000_0010);
    expRam("past_end_zero", 32'd0);
    expErr("err_sticky", 1'b1);
    busRead(32'h8000_4000);

    $display("[TB] serial frame 0x55");
    frame55 = {1'b1, 8'h55, 1'b0};
    busWrite(TXDATA, 32'h55, 4'h1);
    expTx("pre_start_idle", 1'b1);
    expRam("status_queued", 32'h0);
    busRead(STATUS);
    for (int i = 0; i < 40; i++) begin
      expTx("frame55_line", frame55[i / 4]);
      expRam("frame55_status", 32'h6);
      busRead(STATUS);
    end
    expTx("frame55_done", 1'b1);
    expRam("frame55_status_idle", 32'h2);
    expErr("err_still_set", 1'b1);
    busRead(STATUS);

    $display("[TB] fifo overflow");
    for (int k = 1; k <= 10; k++) begin
      busWrite(TXDATA, 32'(k), 4'h1);
    end
    expRam("status_full_ovf", 32'hd);
    expTx("stream_line", txLevel(8));
    busRead(STATUS);
    for (int j = 9; j < 360; j++) begin
      expTx("stream_line", txLevel(j));
      busIdle();
    end
    expTx("stream_done", 1'b1);
    expRam("status_after_stream", 32'ha);
    busRead(STATUS);

    $display("[TB] reset mid-frame");
    busWrite(TXDATA, 32'h00, 4'h1);
    repeat (6) busIdle();
    expTx("data_bit_low", 1'b0);
    busIdle();
    rst_n = 1'b0;
    expTx("async_rst_tx", 1'b1);
    expErr("async_rst_err", 1'b0);
    busIdle();
    busIdle();
    rst_n = 1'b1;
    expRam("mtime_restart", 32'd0);
    busRead(MTIMEL);
    expRam("status_after_rst", 32'h2);
    expTx("tx_idle_after_rst", 1'b1);
    busRead(STATUS);
    expRam("mtime_hi_cleared", 32'd0);
    busRead(MTIMEH);
    expRam("mtime_lo_3", 32'd3);
    busRead(MTIMEL);

    $display("[TB] fetch from mmio");
    expErr("err_before_fetch", 1'b0);
    expRom("mmio_fetch_zero", 32'd0);
    busFetch(MTIMEL);
    expErr("err_after_fetch", 1'b1);
    busIdle();

    busIdle();
    n_checks++;
    if (rom_q.size() + ram_q.size() + tx_q.size() + err_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL pending_expectations: got %0d unconsumed, expected 0",
               rom_q.size() + ram_q.size() + tx_q.size() + err_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
